// File: rtl/fpu_fpr_wb_ctl.sv
// fpu_fpr_wb_ctl: FPR writeback FIFO with per-register busy scoreboard and RAW/WAW issue stall
module fpu_fpr_wb_ctl #(
  parameter int FPLEN = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    rden0,
  input  logic                    rden1,
  input  logic                    rden2,
  input  logic [4:0]              raddr0,
  input  logic [4:0]              raddr1,
  input  logic [4:0]              raddr2,
  output logic                    issue_stall,
  input  logic                    res_valid,
  input  logic [4:0]              res_rd,
  input  logic [FPLEN-1:0]        res_data,
  output logic                    res_ready,
  output logic                    wen0,
  output logic [4:0]              waddr0,
  output logic [FPLEN-1:0]        wd0,
  output logic [31:0]             busy,
  output logic [$clog2(DEPTH):0]  wb_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]       rd_mem_q  [DEPTH];
  logic [4:0]       rd_mem_d  [DEPTH];
  logic [FPLEN-1:0] dat_mem_q [DEPTH];
  logic [FPLEN-1:0] dat_mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic             empty, full, push, pop, hazard, accept;
  // FIFO status, head presentation and hazard detection; a pop never frees a slot for a same-cycle push
  always_comb begin
    empty       = cnt_q == '0;
    full        = cnt_q[AW];
    res_ready   = rst_l & !full;
    push        = res_valid & res_ready;
    pop         = !empty;
    wen0        = !empty;
    waddr0      = empty ? '0 : rd_mem_q[rp_q];
    wd0         = empty ? '0 : dat_mem_q[rp_q];
    hazard      = (rden0 & busy_q[raddr0]) | (rden1 & busy_q[raddr1]) |
                  (rden2 & busy_q[raddr2]) | busy_q[issue_rd];
    issue_stall = issue_valid & hazard;
    accept      = issue_valid & !hazard;
    busy        = busy_q;
    wb_count    = cnt_q;
  end
  // next state: enqueue result, advance pointers, and update scoreboard with set taking priority
  always_comb begin
    rd_mem_d  = rd_mem_q;
    dat_mem_d = dat_mem_q;
    if (push) begin
      rd_mem_d[wp_q]  = res_rd;
      dat_mem_d[wp_q] = res_data;
    end
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    busy_d = (busy_q & ~(32'(pop) << waddr0)) | (32'(accept) << issue_rd);
  end
  // control state, cleared asynchronously so queued results are discarded at once
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
  // FIFO storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    rd_mem_q  <= rd_mem_d;
    dat_mem_q <= dat_mem_d;
  end
endmodule

// File: tb/tb_fpu_fpr_wb_ctl.sv
// tb_fpu_fpr_wb_ctl: scoreboard bench with a queue/bit-array reference model of the writeback controller
module tb_fpu_fpr_wb_ctl;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst_l;
  logic        issue_valid, rden0, rden1, rden2, res_valid;
  logic [4:0]  issue_rd, raddr0, raddr1, raddr2, res_rd;
  logic [15:0] res_data;
  logic        issue_stall, res_ready, wen0;
  logic [4:0]  waddr0;
  logic [15:0] wd0;
  logic [31:0] busy;
  logic [2:0]  wb_count;

  fpu_fpr_wb_ctl #(.FPLEN(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rden0(rden0), .rden1(rden1), .rden2(rden2), .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
    .issue_stall(issue_stall), .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .res_ready(res_ready), .wen0(wen0), .waddr0(waddr0), .wd0(wd0), .busy(busy), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [15:0] data; } wb_t;
  wb_t         mq[$];
  wb_t         sb[$];
  wb_t         e;
  logic [31:0] mbusy = '0;
  logic [31:0] nb;
  bit          ready;
  int          vectors = 0;
  int          errors = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    vectors++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask

  function automatic bit haz(logic [31:0] b);
    return (rden0 && b[raddr0]) || (rden1 && b[raddr1]) || (rden2 && b[raddr2]) || b[issue_rd];
  endfunction

  // reference model: pending writes as a bounded queue, pending registers as a bit array
  initial forever begin
    @(posedge clk or negedge rst_l);
    if (!rst_l) begin
      mq.delete();
      mbusy = '0;
    end else begin
      ready = mq.size() < DEPTH;
      nb = mbusy;
      if (mq.size() != 0) begin
        nb[mq[0].rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (issue_valid && !haz(mbusy)) nb[issue_rd] = 1'b1;
      if (res_valid && ready) begin
        mq.push_back('{res_rd, res_data});
        sb.push_back('{res_rd, res_data});
      end
      mbusy = nb;
    end
  end

  // monitor: compare every cycle, pop the scoreboard whenever the DUT writes
  initial forever begin
    @(negedge clk);
    if (!rst_l) begin
      sb.delete();
      chk("rst_wen0", 32'(wen0), 0);
      chk("rst_ready", 32'(res_ready), 0);
      chk("rst_stall", 32'(issue_stall), 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", 32'(wb_count), 0);
    end else begin
      chk("wen0", 32'(wen0), 32'(mq.size() != 0));
      chk("res_ready", 32'(res_ready), 32'(mq.size() < DEPTH));
      chk("issue_stall", 32'(issue_stall), 32'(issue_valid && haz(mbusy)));
      chk("busy", busy, mbusy);
      chk("wb_count", 32'(wb_count), 32'(mq.size()));
      if (wen0) begin
        if (sb.size() == 0) chk("unexpected_write", 32'(wen0), 0);
        else begin
          e = sb.pop_front();
          chk("waddr0", 32'(waddr0), 32'(e.rd));
          chk("wd0", 32'(wd0), 32'(e.data));
        end
      end else chk("idle_bus", {11'd0, waddr0, wd0}, 0);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_res(logic [4:0] rd, logic [15:0] d);
    int w = 0;
    res_valid = 1'b1; res_rd = rd; res_data = d;
    while (!res_ready && w < 10) begin cyc(1); w++; end
    if (w == 10) chk("ready_timeout", 32'(res_ready), 1);
    cyc(1);
    res_valid = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; issue_valid = 0; issue_rd = 0; rden0 = 0; rden1 = 0; rden2 = 0;
    raddr0 = 0; raddr1 = 0; raddr2 = 0; res_valid = 1'b1; res_rd = 5'd1; res_data = 16'h1234;
    cyc(3);
    chk("t1_ready_in_rst", 32'(res_ready), 0);
    chk("t1_wen_in_rst", 32'(wen0), 0);
    res_valid = 1'b0;
    rst_l = 1'b1;
    #1;
    chk("t1_ready_after", 32'(res_ready), 1);
    chk("t1_count_after", 32'(wb_count), 0);
    cyc(1);
    // basic issue then writeback of f5
    issue_valid = 1; issue_rd = 5'd5;
    cyc(1);
    issue_valid = 0;
    chk("t2_busy_set", 32'(busy[5]), 1);
    push_res(5'd5, 16'h3F80);
    chk("t2_wen0", 32'(wen0), 1);
    chk("t2_waddr0", 32'(waddr0), 5);
    chk("t2_wd0", 32'(wd0), 32'h3F80);
    chk("t2_busy_held", 32'(busy[5]), 1);
    cyc(1);
    chk("t2_busy_clear", 32'(busy[5]), 0);
    // RAW on f7
    issue_valid = 1; issue_rd = 5'd7;
    cyc(1);
    issue_rd = 5'd10; rden1 = 1; raddr1 = 5'd7;
    cyc(2);
    chk("t3_raw_stall", 32'(issue_stall), 1);
    push_res(5'd7, 16'h4000);
    chk("t3_raw_stall_head", 32'(issue_stall), 1);
    cyc(1);
    chk("t3_raw_release", 32'(issue_stall), 0);
    issue_valid = 0; rden1 = 0;
    push_res(5'd10, 16'h4040);
    cyc(1);
    // WAW on f7
    issue_valid = 1; issue_rd = 5'd7;
    cyc(2);
    chk("t3_waw_stall", 32'(issue_stall), 1);
    issue_valid = 0;
    push_res(5'd7, 16'h4080);
    cyc(1);
    chk("t3_waw_clear", 32'(busy[7]), 0);
    // back-to-back results drain in order
    for (int i = 0; i < 5; i++) push_res(5'(16 + i), 16'($urandom));
    cyc(2);
    // pop of f3 while a stalled issue targets f3
    issue_valid = 1; issue_rd = 5'd3;
    cyc(1);
    push_res(5'd3, 16'hBF80);
    chk("t5_stall_at_pop", 32'(issue_stall), 1);
    cyc(1);
    issue_valid = 0;
    chk("t5_busy3_zero", 32'(busy[3]), 0);
    // set and clear of the same bit: write of non-pending f9 coinciding with issue of f9
    push_res(5'd9, 16'h1111);
    issue_valid = 1; issue_rd = 5'd9;
    #1;
    chk("t5_no_stall", 32'(issue_stall), 0);
    cyc(1);
    issue_valid = 0;
    chk("t5_set_wins", 32'(busy[9]), 1);
    push_res(5'd9, 16'h2222);
    cyc(2);
    // randomized traffic on a small register window so hazards occur often
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom); issue_rd = 5'($urandom_range(0, 15));
      rden0 = 1'($urandom); rden1 = 1'($urandom); rden2 = 1'($urandom);
      raddr0 = 5'($urandom_range(0, 15)); raddr1 = 5'($urandom_range(0, 15));
      raddr2 = 5'($urandom_range(0, 15));
      res_valid = 1'($urandom); res_rd = 5'($urandom_range(0, 15)); res_data = 16'($urandom);
      cyc(1);
    end
    issue_valid = 0; rden0 = 0; rden1 = 0; rden2 = 0; res_valid = 0;
    cyc(2);
    // reset in the middle of a drain
    issue_valid = 1; issue_rd = 5'd12;
    cyc(1);
    issue_valid = 0;
    res_valid = 1; res_rd = 5'd12; res_data = 16'h5555;
    cyc(1);
    res_rd = 5'd13; res_data = 16'h6666;
    cyc(1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("t6_wen0_now", 32'(wen0), 0);
    chk("t6_busy_now", busy, 0);
    chk("t6_count_now", 32'(wb_count), 0);
    cyc(2);
    res_valid = 0;
    rst_l = 1'b1;
    cyc(4);
    chk("t6_no_stale", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
